// File: rtl/wb_slave_reg_bank.sv
// Wishbone classic slave: eight byte registers, programmable ACK wait states,
// and a TX byte FIFO drained through a valid/pop port.
module wb_slave_reg_bank #(
  parameter int         ACK_DELAY     = 1,
  parameter int         FIFO_DEPTH    = 8,
  parameter logic [7:0] SCRATCH_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] wbs_adr_i,
  input  logic [7:0] wbs_dat_i,
  output logic [7:0] wbs_dat_o,
  input  logic       wbs_we_i,
  input  logic       wbs_stb_i,
  input  logic       wbs_cyc_i,
  output logic       wbs_ack_o,
  output logic [7:0] ctrl_o,
  input  logic       irq_event_i,
  output logic       irq_o,
  output logic [7:0] fifo_dout_o,
  output logic       fifo_valid_o,
  input  logic       fifo_pop_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] WAIT_INIT = (ACK_DELAY == 0) ? 4'd0 : 4'(ACK_DELAY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t state, state_nxt;

  logic [3:0]    cnt, cnt_nxt;
  logic [2:0]    adr_q, c_adr;
  logic          we_q, c_we, commit, wr;
  logic [7:0]    dat_q, c_dat, rd_q, rd_val, ctrl;
  logic [1:0]    irq;
  logic [7:0]    scratch [4];
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop_ok, push_req, push_ok, overflow;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      S_IDLE: if (wbs_cyc_i && wbs_stb_i) begin
        if (ACK_DELAY == 0) begin
          state_nxt = S_ACK;
          commit    = 1'b1;
        end else begin
          state_nxt = S_WAIT;
          cnt_nxt   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) state_nxt = S_IDLE;
        else if (cnt == 4'd0) begin
          state_nxt = S_ACK;
          commit    = 1'b1;
        end else cnt_nxt = cnt - 4'd1;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      adr_q <= 3'd0;
      we_q  <= 1'b0;
      dat_q <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && wbs_cyc_i && wbs_stb_i) begin
        adr_q <= wbs_adr_i;
        we_q  <= wbs_we_i;
        dat_q <= wbs_dat_i;
      end
    end
  end

  // With zero wait states the commit edge is the capture edge, so use the live bus.
  assign c_adr = (state == S_IDLE) ? wbs_adr_i : adr_q;
  assign c_we  = (state == S_IDLE) ? wbs_we_i  : we_q;
  assign c_dat = (state == S_IDLE) ? wbs_dat_i : dat_q;
  assign wr    = commit && c_we;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = fifo_pop_i && !empty;
  assign push_req = wr && (c_adr == 3'd2);
  assign push_ok  = push_req && (!full || pop_ok);
  assign overflow = push_req && full && !pop_ok;

  always_comb begin
    rd_val = 8'h00;
    case (c_adr)
      3'd0:    rd_val = ctrl;
      3'd1:    rd_val = {full, empty, 2'b00, 4'(count)};
      3'd2:    rd_val = 8'h00;
      3'd3:    rd_val = {6'b0, irq};
      default: rd_val = scratch[c_adr[1:0]];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl   <= 8'h00;
      irq    <= 2'b00;
      rd_q   <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < 4; i++) scratch[i] <= SCRATCH_RESET;
    end else begin
      if (commit) rd_q <= rd_val;
      if (wr && c_adr == 3'd0) ctrl <= c_dat;
      if (wr && c_adr[2]) scratch[c_adr[1:0]] <= c_dat;
      // Hardware set terms are OR-ed after the W1C mask so a same-cycle set wins.
      irq <= (irq & ~((wr && c_adr == 3'd3) ? c_dat[1:0] : 2'b00)) | {overflow, irq_event_i};
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count  <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= c_dat;
  end

  assign wbs_ack_o    = (state == S_ACK);
  assign wbs_dat_o    = wbs_ack_o ? rd_q : 8'h00;
  assign ctrl_o       = ctrl;
  assign irq_o        = |(irq & ctrl[7:6]);
  assign fifo_valid_o = !empty;
  assign fifo_dout_o  = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_wb_slave_reg_bank.sv
// Bench for wb_slave_reg_bank: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_slave_reg_bank;
  localparam int DLY = 1, DEPTH = 8;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] adr = '0;
  logic [7:0] dat_i = '0;
  logic       we = 0, stb = 0, cyc = 0, pop = 0, ev = 0;
  logic [7:0] dat_o, ctrl_o, dout;
  logic       ack, irq_o, valid;

  logic [2:0] a3 = '0;
  logic [7:0] d3 = '0;
  logic       w3 = 0, stb3 = 0, cyc3 = 0;
  logic [7:0] dat3_o, ctrl3_o, dout3;
  logic       ack3, irq3_o, valid3;

  wb_slave_reg_bank #(.ACK_DELAY(DLY), .FIFO_DEPTH(DEPTH), .SCRATCH_RESET(8'h00)) u_dut (
    .clk(clk), .reset_n(reset_n), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o),
    .wbs_we_i(we), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_ack_o(ack), .ctrl_o(ctrl_o),
    .irq_event_i(ev), .irq_o(irq_o), .fifo_dout_o(dout), .fifo_valid_o(valid), .fifo_pop_i(pop));

  wb_slave_reg_bank #(.ACK_DELAY(3), .FIFO_DEPTH(4), .SCRATCH_RESET(8'h5A)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .wbs_adr_i(a3), .wbs_dat_i(d3), .wbs_dat_o(dat3_o),
    .wbs_we_i(w3), .wbs_stb_i(stb3), .wbs_cyc_i(cyc3), .wbs_ack_o(ack3), .ctrl_o(ctrl3_o),
    .irq_event_i(1'b0), .irq_o(irq3_o), .fifo_dout_o(dout3), .fifo_valid_o(valid3), .fifo_pop_i(1'b0));

  int checks = 0, failures = 0;
  logic chk_en = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Transaction-level model: a request captured at edge N commits at edge N+DLY
  // unless cyc drops first; ack is visible in the cycle after the commit edge.
  logic       m_ack, m_pend, m_cm, m_w, m_pop, m_push, m_ovf;
  int         m_left, sz;
  logic [2:0] m_a;
  logic [7:0] m_d, m_rd, m_dat, m_ctrl;
  logic [1:0] m_irq;
  logic [7:0] m_scr [4];
  logic [7:0] m_q [$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ack = 0; m_pend = 0; m_left = 0; m_dat = 0; m_ctrl = 0; m_irq = 0;
      m_a = 0; m_w = 0; m_d = 0;
      for (int i = 0; i < 4; i++) m_scr[i] = 8'h00;
      m_q.delete();
    end else begin
      m_cm = 0;
      if (m_ack) m_ack = 0;
      else if (m_pend && !cyc) m_pend = 0;
      else begin
        if (!m_pend && cyc && stb) begin
          m_pend = 1; m_left = DLY; m_a = adr; m_w = we; m_d = dat_i;
        end
        if (m_pend) begin
          if (m_left == 0) begin m_cm = 1; m_pend = 0; end
          else m_left--;
        end
      end
      sz = m_q.size();
      m_rd = 8'h00;
      case (m_a)
        3'd0: m_rd = m_ctrl;
        3'd1: m_rd = {sz == DEPTH, sz == 0, 2'b00, 4'(sz)};
        3'd2: m_rd = 8'h00;
        3'd3: m_rd = {6'b0, m_irq};
        default: m_rd = m_scr[m_a[1:0]];
      endcase
      m_pop  = pop && sz > 0;
      m_push = m_cm && m_w && m_a == 3'd2;
      m_ovf  = m_push && sz == DEPTH && !m_pop;
      if (m_pop) void'(m_q.pop_front());
      if (m_push && !m_ovf) m_q.push_back(m_d);
      if (m_cm && m_w) begin
        case (m_a)
          3'd0: m_ctrl = m_d;
          3'd3: m_irq = m_irq & ~m_d[1:0];
          3'd4, 3'd5, 3'd6, 3'd7: m_scr[m_a[1:0]] = m_d;
          default: ;
        endcase
      end
      if (ev) m_irq[0] = 1'b1;
      if (m_ovf) m_irq[1] = 1'b1;
      if (m_cm) m_dat = m_rd;
      m_ack = m_cm;
    end
  end

  logic [26:0] exp_v, got_v;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = {m_ack, m_ack ? m_dat : 8'h00, m_ctrl, |(m_irq & m_ctrl[7:6]),
               m_q.size() != 0, m_q.size() != 0 ? m_q[0] : 8'h00};
      got_v = {ack, dat_o, ctrl_o, irq_o, valid, dout};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL model_cmp t=%0t {ack,dat,ctrl,irq,valid,dout} got=%h exp=%h", $time, got_v, exp_v);
      end
    end
  end

  task automatic bus(input logic [2:0] a, input logic w, input logic [7:0] d,
                     input logic pc, input logic ec, output logic [7:0] rd, output int lat);
    @(negedge clk);
    adr = a; we = w; dat_i = d; cyc = 1; stb = 1;
    pop = pc && (DLY == 0); ev = ec && (DLY == 0);
    lat = -1; rd = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      pop = pc && (k == DLY); ev = ec && (k == DLY);
      if (ack) begin lat = k; rd = dat_o; break; end
    end
    cyc = 0; stb = 0; we = 0; pop = 0; ev = 0;
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL bus_timeout adr=%0d got=no_ack exp=ack", a);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] r; int l;
    bus(a, 1'b1, d, 1'b0, 1'b0, r, l);
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] r);
    int l;
    bus(a, 1'b0, 8'h00, 1'b0, 1'b0, r, l);
  endtask

  task automatic pop1();
    @(negedge clk); pop = 1;
    @(negedge clk); pop = 0;
  endtask

  task automatic bus3(input logic [2:0] a, input logic w, input logic [7:0] d,
                      output logic [7:0] r, output int lat);
    @(negedge clk);
    a3 = a; w3 = w; d3 = d; cyc3 = 1; stb3 = 1;
    lat = -1; r = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack3) begin lat = k; r = dat3_o; break; end
    end
    cyc3 = 0; stb3 = 0; w3 = 0;
  endtask

  initial begin
    logic [7:0] r;
    int l;
    logic seen;
    repeat (3) @(negedge clk);
    reset_n = 1;
    chk_en = 1;
    @(negedge clk);
    chk("reset_outs", {ack, dat_o, ctrl_o, irq_o, valid, dout}, 32'h0);
    chk("reset_outs3", {ack3, dat3_o, ctrl3_o, irq3_o, valid3, dout3}, 32'h0);

    bus(3'd5, 1'b0, 8'h00, 1'b0, 1'b0, r, l);
    chk("scr5_latency", l, 2);
    chk("scr5_data", r, 8'h00);

    wr(3'd0, 8'hC1);
    rd(3'd0, r);
    chk("ctrl_readback", r, 8'hC1);
    chk("ctrl_o", ctrl_o, 8'hC1);
    rd(3'd1, r);
    chk("status_empty", r, 8'h40);

    for (int i = 0; i < 8; i++) wr(3'd2, 8'h10 + 8'(i));
    rd(3'd1, r);
    chk("status_full", r, 8'h88);
    wr(3'd2, 8'hFF);
    rd(3'd3, r);
    chk("irq_overflow", r, 8'h02);
    chk("irq_o_overflow", irq_o, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("pop_order", dout, 8'h10 + 8'(i));
      pop1();
    end
    @(negedge clk);
    chk("drained_valid", valid, 1'b0);
    wr(3'd3, 8'h03);
    chk("irq_o_cleared", irq_o, 1'b0);

    for (int i = 0; i < 8; i++) wr(3'd2, 8'hA0 + 8'(i));
    bus(3'd2, 1'b1, 8'hB8, 1'b1, 1'b0, r, l);
    rd(3'd1, r);
    chk("push_pop_full_status", r, 8'h88);
    rd(3'd3, r);
    chk("push_pop_full_no_ovf", r, 8'h00);
    for (int i = 0; i < 7; i++) pop1();
    @(negedge clk);
    chk("new_tail", dout, 8'hB8);
    pop1();

    @(negedge clk); ev = 1;
    @(negedge clk); ev = 0;
    bus(3'd3, 1'b1, 8'h01, 1'b0, 1'b1, r, l);
    rd(3'd3, r);
    chk("set_beats_w1c", r, 8'h01);
    chk("irq_o_event", irq_o, 1'b1);
    wr(3'd3, 8'h01);
    rd(3'd3, r);
    chk("w1c_event", r, 8'h00);
    chk("irq_o_event_clr", irq_o, 1'b0);

    for (int n = 0; n < 80; n++) begin
      logic [2:0] a;
      logic w;
      a = ($urandom_range(0, 9) < 3) ? 3'd2 : 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 9) < 6);
      bus(a, w, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, r, l);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        pop = ($urandom_range(0, 2) == 0);
        ev  = ($urandom_range(0, 9) == 0);
      end
      @(negedge clk); pop = 0; ev = 0;
    end

    // Abort during wait states on the 3-wait-state instance.
    @(negedge clk);
    a3 = 3'd6; w3 = 1; d3 = 8'hAA; cyc3 = 1; stb3 = 1;
    seen = 0;
    repeat (2) begin @(negedge clk); seen |= ack3; end
    cyc3 = 0; stb3 = 0; w3 = 0;
    repeat (5) begin @(negedge clk); seen |= ack3; end
    chk("abort_no_ack", seen, 1'b0);
    bus3(3'd6, 1'b0, 8'h00, r, l);
    chk("abort_scratch_kept", r, 8'h5A);
    chk("delay3_latency", l, 4);
    bus3(3'd2, 1'b1, 8'h77, r, l);
    @(negedge clk);
    chk("dut3_push", {valid3, dout3}, {1'b1, 8'h77});

    @(negedge clk);
    a3 = 3'd0; cyc3 = 1; stb3 = 1;
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("rst_mid_wait", {ack3, valid3, dout3}, 32'h0);
    cyc3 = 0; stb3 = 0;
    @(negedge clk);
    reset_n = 1;
    seen = 0;
    repeat (5) begin @(negedge clk); seen |= ack3; end
    chk("post_reset_quiet", {seen, valid3}, 32'h0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
